// File: rtl/torus_pkg.sv
// Shared constants and FSM state type for the torus output collector.
package torus_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/torus_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module torus_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/torus_out_collector.sv
// Captures 4-lane torus results into a FIFO and serializes them one lane per beat.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_CAPTURE | writing one 4-lane word per cycle for sample_cnt cycles
//   S_DRAIN   | emptying FIFO and serializer downstream
//   S_DONE    | one-cycle completion pulse
module torus_out_collector
  import torus_pkg::*;
#(
  parameter int DATA_W = torus_pkg::DATA_W,
  parameter int DEPTH  = torus_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        sample_cnt,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_lane,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int WORD_W = NUM_LANES * DATA_W + 1;

  state_e            state_q;
  logic [7:0]        remaining_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;

  logic [WORD_W-1:0] fifo_wdata;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  logic [WORD_W-1:0] ser_word_q;
  logic              ser_valid_q;
  logic [1:0]        lane_q;

  logic              beat_acc;
  logic              lane3_acc;
  logic              write_ok;
  logic              drain_done;

  // Top bit of each word tags the final sample of the capture.
  assign fifo_wdata = {(remaining_q == 8'd1), data_in3, data_in2, data_in1, data_in0};
  assign beat_acc   = ser_valid_q && m_ready;
  assign lane3_acc  = beat_acc && (lane_q == 2'd3);
  assign fifo_pop   = !fifo_empty && (!ser_valid_q || lane3_acc);
  assign write_ok   = !fifo_full || fifo_pop;
  assign fifo_push  = (state_q == S_CAPTURE) && write_ok;
  // Leave DRAIN on the same edge that retires the last beat.
  assign drain_done = fifo_empty && (!ser_valid_q || lane3_acc);

  torus_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            overflow_q <= 1'b0;
            if (sample_cnt != 8'd0) begin
              state_q     <= S_CAPTURE;
              remaining_q <= sample_cnt;
              busy_q      <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          remaining_q <= remaining_q - 8'd1;
          if (!write_ok) overflow_q <= 1'b1;
          if (remaining_q == 8'd1) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_word_q  <= '0;
      ser_valid_q <= 1'b0;
      lane_q      <= 2'd0;
    end else if (fifo_pop) begin
      ser_word_q  <= fifo_rdata;
      ser_valid_q <= 1'b1;
      lane_q      <= 2'd0;
    end else if (beat_acc) begin
      if (lane_q == 2'd3) begin
        ser_valid_q <= 1'b0;
        lane_q      <= 2'd0;
      end else begin
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign m_valid  = ser_valid_q;
  assign m_data   = ser_valid_q ? ser_word_q[int'(lane_q) * DATA_W +: DATA_W] : '0;
  assign m_lane   = ser_valid_q ? lane_q : 2'd0;
  assign m_last   = ser_valid_q && ser_word_q[WORD_W-1] && (lane_q == 2'd3);
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
